// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared FSM states, bus constants and pointer arithmetic for the I2C register slave
package i2c_slave_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_e;
  localparam logic ACK_LVL = 1'b0;
  localparam int BIT_CNT_W = 4;
  // Pointer advances by one; anything at or past the status register wraps back to register 0.
  function automatic logic [7:0] ptr_next(input logic [7:0] ptr, input int num_regs);
    return (int'(ptr) >= num_regs) ? 8'd0 : ptr + 8'd1;
  endfunction
endpackage

// File: rtl/i2c_slave_regfile_line_filter.sv
// i2c_line_filter: pad synchronizer plus run-length glitch filter with one-cycle edge pulses
module i2c_line_filter
  import i2c_slave_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_in,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  // Count consecutive synchronized samples that disagree with the filtered level; flip after FILTER_LEN.
  always_comb begin
    sync_d = {sync_q[0], pad_in};
    cnt_d = '0;
    level_d = level_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        rise_d = sync_q[1];
        fall_d = ~sync_q[1];
      end else cnt_d = cnt_q + 1'b1;
    end
  end
  // Filter state registers; the idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q <= '0;
      level_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign level = level_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave exposing an 8-bit register bank plus a read-only status register
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h42,
  parameter int NUM_REGS = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  output logic [NUM_REGS*8-1:0] reg_out,
  input  logic [7:0] stat_in,
  output logic wr_strobe,
  output logic [$clog2(NUM_REGS+1)-1:0] wr_index,
  output logic busy
);
  localparam int IW = $clog2(NUM_REGS + 1);
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [BIT_CNT_W-1:0] FULL = BIT_CNT_W'(8);
  state_e state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d, rd_byte;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [IW-1:0] wr_index_q, wr_index_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic first_q, first_d, rw_q, rw_d;
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c, in_range;
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .reset(reset), .pad_in(scl_in), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .reset(reset), .pad_in(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );
  assign start_c = sda_fall & scl_lvl;
  assign stop_c = sda_rise & scl_lvl;
  assign in_range = int'(ptr_q) < NUM_REGS;
  assign rd_byte = in_range ? regs_q[ptr_q[RW-1:0]] : (int'(ptr_q) == NUM_REGS) ? stat_in : 8'hFF;
  // Bus protocol sequencing: START/STOP win over SCL edges; bits sampled on rise, SDA driven on fall.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    tx_d = tx_q;
    ptr_d = ptr_q;
    regs_d = regs_q;
    sda_oe_d = sda_oe_q;
    busy_d = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d = wr_index_q;
    first_d = first_q;
    rw_d = rw_q;
    if (stop_c) begin
      state_d = IDLE;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (start_c) begin
      state_d = ADDR;
      cnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      if ((state_q == ADDR || state_q == WR_BYTE) && cnt_q < FULL) begin
        shift_d = {shift_q[6:0], sda_lvl};
        cnt_d = cnt_q + 1'b1;
      end else if (state_q == RD_ACK && cnt_q == '0) begin
        if (sda_lvl == ACK_LVL) begin
          ptr_d = ptr_next(ptr_q, NUM_REGS);
          cnt_d = BIT_CNT_W'(1);
        end else state_d = IGNORE;
      end
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (cnt_q == FULL) begin
          rw_d = shift_q[0];
          sda_oe_d = shift_q[7:1] == I2C_ADDR;
          busy_d = busy_q | (shift_q[7:1] == I2C_ADDR);
          state_d = (shift_q[7:1] == I2C_ADDR) ? ADDR_ACK : IGNORE;
        end
        ADDR_ACK, RD_ACK: if (state_q == ADDR_ACK || cnt_q != '0) begin
          first_d = 1'b1;
          cnt_d = rw_q ? BIT_CNT_W'(1) : '0;
          sda_oe_d = rw_q & ~rd_byte[7];
          tx_d = {rd_byte[6:0], 1'b0};
          state_d = rw_q ? RD_BYTE : WR_BYTE;
        end
        WR_BYTE: if (cnt_q == FULL) begin
          sda_oe_d = 1'b1;
          state_d = WR_ACK;
          first_d = 1'b0;
          ptr_d = first_q ? shift_q : ptr_next(ptr_q, NUM_REGS);
          if (!first_q && in_range) begin
            regs_d[ptr_q[RW-1:0]] = shift_q;
            wr_strobe_d = 1'b1;
            wr_index_d = IW'(ptr_q);
          end
        end
        WR_ACK: begin
          sda_oe_d = 1'b0;
          cnt_d = '0;
          state_d = WR_BYTE;
        end
        RD_BYTE: begin
          sda_oe_d = (cnt_q == FULL) ? 1'b0 : ~tx_q[7];
          tx_d = {tx_q[6:0], 1'b0};
          cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == FULL) ? RD_ACK : RD_BYTE;
        end
        default: ;
      endcase
    end
  end
  // Protocol state registers; reset clears the bank and releases SDA immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      tx_q <= '0;
      ptr_q <= '0;
      regs_q <= '{default: '0};
      sda_oe_q <= 1'b0;
      busy_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q <= '0;
      first_q <= 1'b0;
      rw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ptr_q <= ptr_d;
      regs_q <= regs_d;
      sda_oe_q <= sda_oe_d;
      busy_q <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q <= wr_index_d;
      first_q <= first_d;
      rw_q <= rw_d;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[8*i +: 8] = regs_q[i];
  end
  assign sda_oe = sda_oe_q;
  assign busy = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index = wr_index_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bus-master driven bench checking the register slave against a transaction-level model
module tb_i2c_slave_regfile;
  localparam int Q = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic [7:0] stat_in = 8'h00;
  logic sda_oe, wr_strobe, busy;
  logic [63:0] reg_out;
  logic [3:0] wr_index;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] regs_m [8];
  int ptr_m = 0;
  int exp_idx[$];
  logic [7:0] dq[$];
  int strobe_n = 0;
  int strobe_rd = 0;
  int oe_cnt = 0;
  logic [3:0] strobe_idx [256];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .reg_out(reg_out), .stat_in(stat_in), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) begin
      strobe_idx[strobe_n[7:0]] <= wr_index;
      strobe_n <= strobe_n + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic v, input bit glitch, output logic s);
    wq(Q);
    sda_m = v;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    if (glitch) begin
      scl_m = 1'b0;
      wq(2);
      scl_m = 1'b1;
      wq(Q);
    end
    s = sda_bus;
    wq(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop;
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b1;
    wq(2 * Q);
  endtask

  task automatic wbyte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) sbit(b[i], i == gbit, s);
    sbit(1'b1, 1'b0, ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      sbit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    sbit(nack, 1'b0, s);
  endtask

  function automatic int inc(input int p);
    return (p >= 8) ? 0 : p + 1;
  endfunction

  function automatic logic [7:0] rd_exp(input int p);
    return (p < 8) ? regs_m[p] : (p == 8) ? stat_in : 8'hFF;
  endfunction

  task automatic check_regs;
    logic [63:0] e;
    for (int i = 0; i < 8; i++) e[8*i +: 8] = regs_m[i];
    check("reg_out", reg_out, e);
  endtask

  task automatic check_strobes;
    check("strobe_count", 64'(strobe_n - strobe_rd), 64'(exp_idx.size()));
    while (exp_idx.size() > 0) begin
      int e;
      e = exp_idx.pop_front();
      if (strobe_rd < strobe_n) check("wr_index", 64'(strobe_idx[strobe_rd[7:0]]), 64'(e));
      strobe_rd++;
    end
    strobe_rd = strobe_n;
  endtask

  task automatic do_write(input int p, input int gbit);
    logic a;
    i2c_start;
    wbyte(8'h84, -1, a);
    check("addr_ack_w", a, 0);
    check("busy_w", busy, 1);
    wbyte(8'(p), -1, a);
    check("ptr_ack", a, 0);
    ptr_m = p;
    foreach (dq[k]) begin
      wbyte(dq[k], (k == 0) ? gbit : -1, a);
      check("data_ack", a, 0);
      if (ptr_m < 8) begin
        regs_m[ptr_m] = dq[k];
        exp_idx.push_back(ptr_m);
      end
      ptr_m = inc(ptr_m);
    end
    i2c_stop;
    check("busy_after_stop", busy, 0);
    check_regs;
    check_strobes;
  endtask

  task automatic do_read(input int p, input int n);
    logic a;
    logic [7:0] d;
    i2c_start;
    wbyte(8'h84, -1, a);
    check("addr_ack_w", a, 0);
    wbyte(8'(p), -1, a);
    check("ptr_ack", a, 0);
    ptr_m = p;
    i2c_start;
    wbyte(8'h85, -1, a);
    check("addr_ack_r", a, 0);
    check("busy_r", busy, 1);
    for (int k = 0; k < n; k++) begin
      rbyte(k == n - 1, d);
      check("rd_data", d, rd_exp(ptr_m));
      if (k < n - 1) ptr_m = inc(ptr_m);
    end
    i2c_stop;
    check("busy_after_stop", busy, 0);
  endtask

  initial begin
    logic a;
    int oe0;
    for (int i = 0; i < 8; i++) regs_m[i] = 8'h00;
    wq(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_out", reg_out, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_index", wr_index, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    wq(5);
    dq = {8'hA5, 8'h3C};
    do_write(2, -1);
    dq = {8'h11};
    do_write(0, -1);
    stat_in = 8'h5A;
    do_read(7, 3);
    oe0 = oe_cnt;
    i2c_start;
    wbyte(8'h90, -1, a);
    check("mismatch_nack", a, 1);
    wbyte(8'h00, -1, a);
    wbyte(8'hFF, -1, a);
    check("mismatch_busy", busy, 0);
    i2c_stop;
    check("mismatch_oe_quiet", 64'(oe_cnt - oe0), 0);
    check_regs;
    check_strobes;
    dq = {8'h77};
    do_write(8'h0C, -1);
    do_read(8'h0C, 1);
    dq = {8'h96};
    do_write(5, 3);
    for (int r = 0; r < 6; r++) begin
      dq = {};
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) dq.push_back(8'($urandom));
      do_write(int'($urandom_range(0, 10)), -1);
      stat_in = 8'($urandom);
      do_read(int'($urandom_range(0, 10)), int'($urandom_range(1, 4)));
    end
    i2c_start;
    wbyte(8'h84, -1, a);
    wbyte(8'h01, -1, a);
    for (int i = 0; i < 3; i++) sbit(1'b1, 1'b0, a);
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b1;
    wq(Q / 2);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_sda_oe", sda_oe, 0);
    check("rst_mid_reg_out", reg_out, 0);
    check("rst_mid_busy", busy, 0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    wq(4);
    reset = 1'b0;
    wq(5);
    for (int i = 0; i < 8; i++) regs_m[i] = 8'h00;
    ptr_m = 0;
    strobe_rd = strobe_n;
    exp_idx = {};
    dq = {8'hC3, 8'h5E};
    do_write(4, -1);
    do_read(4, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
